// File: rtl/vga_cell_framebuffer_pkg.sv
// vga_pkg: shared timing constants, color codes, clear FSM states and cell address helper
package vga_pkg;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int H_VIS = 640;
  localparam int V_VIS = 480;
  localparam int CELL_SHIFT = 4;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int CELLS = COLS * ROWS;
  typedef enum logic [2:0] {BLACK, BLUE, BROWN, CYAN, RED, MAGENTA, YELLOW, WHITE} color_t;
  typedef enum logic {IDLE, FILL} fill_state_t;
  // row*40 + col without a multiplier
  function automatic logic [10:0] cell_addr(input logic [4:0] y, input logic [5:0] x);
    return (11'(y) << 5) + (11'(y) << 3) + 11'(x);
  endfunction
endpackage

// File: rtl/vga_cell_framebuffer_if.sv
// vga_cell_framebuffer_if: game-logic write/clear port and pixel outputs of the framebuffer
interface vga_cell_framebuffer_if;
  logic       wr_en;
  logic [5:0] wr_x;
  logic [4:0] wr_y;
  logic [2:0] wr_color;
  logic       clr;
  logic [2:0] clr_color;
  logic       clr_busy;
  logic       vblank;
  logic       frame_start;
  logic [2:0] color;
  modport master (output wr_en, wr_x, wr_y, wr_color, clr, clr_color,
                  input clr_busy, vblank, frame_start, color);
  modport slave (input wr_en, wr_x, wr_y, wr_color, clr, clr_color,
                 output clr_busy, vblank, frame_start, color);
endinterface

// File: rtl/vga_cell_framebuffer_cell_ram.sv
// cell_ram: 1200x3 simple dual-port block RAM, registered read, old data on same-address collision
module cell_ram
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        i_we,
  input  logic [10:0] i_wa,
  input  logic [2:0]  i_wd,
  input  logic [10:0] i_ra,
  output logic [2:0]  o_q
);
  logic [2:0] r_mem [CELLS];
  // one write and one registered read per clock, no reset so it maps to block RAM
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
    o_q <= r_mem[i_ra];
  end
endmodule

// File: rtl/vga_cell_framebuffer.sv
// vga_cell_framebuffer: 40x30 color-cell framebuffer with VGA scan counters and bulk clear
module vga_cell_framebuffer
  import vga_pkg::*;
(
  input logic clk,
  input logic rst,
  vga_cell_framebuffer_if.slave bus
);
  logic [9:0]  r_h, r_v;
  logic        r_vis, r_vblank, r_fs;
  fill_state_t r_state;
  logic [10:0] r_fill_addr;
  logic [2:0]  r_fill_color;
  logic        w_h_wrap, w_busy, w_wr_ok, w_we, w_vis;
  logic [9:0]  w_h_nxt, w_v_nxt;
  logic [10:0] w_rd_addr, w_wa;
  logic [2:0]  w_wd, w_q;
  assign w_h_wrap = r_h == 10'(H_TOTAL - 1);
  assign w_h_nxt = w_h_wrap ? 10'd0 : r_h + 10'd1;
  assign w_v_nxt = !w_h_wrap ? r_v : (r_v == 10'(V_TOTAL - 1)) ? 10'd0 : r_v + 10'd1;
  assign w_vis = (w_h_nxt < 10'(H_VIS)) && (w_v_nxt < 10'(V_VIS));
  assign w_rd_addr = cell_addr(5'(w_v_nxt >> CELL_SHIFT), 6'(w_h_nxt >> CELL_SHIFT));
  assign w_busy = r_state == FILL;
  assign w_wr_ok = bus.wr_en && !w_busy && (bus.wr_x < 6'(COLS)) && (bus.wr_y < 5'(ROWS));
  assign w_we = !bus.clr && (w_busy || w_wr_ok);
  assign w_wa = w_busy ? r_fill_addr : cell_addr(bus.wr_y, bus.wr_x);
  assign w_wd = w_busy ? r_fill_color : bus.wr_color;
  // scan counters and flags are computed from the next pixel so they line up with the RAM read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h      <= '0;
      r_v      <= '0;
      r_vis    <= 1'b0;
      r_vblank <= 1'b0;
      r_fs     <= 1'b0;
    end else begin
      r_h      <= w_h_nxt;
      r_v      <= w_v_nxt;
      r_vis    <= w_vis;
      r_vblank <= w_v_nxt >= 10'(V_VIS);
      r_fs     <= (w_h_nxt == 10'd0) && (w_v_nxt == 10'd0);
    end
  end
  // clear engine: clr (re)starts at cell 0, then one cell per clock through the last cell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fill_addr  <= '0;
      r_fill_color <= '0;
    end else if (bus.clr) begin
      r_state      <= FILL;
      r_fill_addr  <= '0;
      r_fill_color <= bus.clr_color;
    end else if (w_busy) begin
      r_state     <= (r_fill_addr == 11'(CELLS - 1)) ? IDLE : FILL;
      r_fill_addr <= r_fill_addr + 11'd1;
    end
  end
  cell_ram u_ram (
    .clk  (clk),
    .i_we (w_we),
    .i_wa (w_wa),
    .i_wd (w_wd),
    .i_ra (w_rd_addr),
    .o_q  (w_q)
  );
  assign bus.color = r_vis ? w_q : 3'd0;
  assign bus.clr_busy = w_busy;
  assign bus.vblank = r_vblank;
  assign bus.frame_start = r_fs;
endmodule

// File: tb/tb_vga_cell_framebuffer.sv
// tb_vga_cell_framebuffer: table, hand-sequenced and random checks against a frame-level model
module tb_vga_cell_framebuffer;
  import vga_pkg::*;
  typedef struct {int x; int y; int c;} wr_t;
  typedef struct {int h; int v; int e;} pix_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;
  vga_cell_framebuffer_if bus();
  vga_cell_framebuffer dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  int mem[1200];
  int n = 0;
  int m_busy = 0, m_fa = 0, m_fc = 0;
  int exp_color = 0, exp_vb = 0, exp_fs = 0;
  bit chk_en = 0;
  wr_t wrs[8];
  pix_t pix[15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (frame pos %0d)", name, act, exp, n);
      if (errors > 200) begin
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  endtask

  // frame-level model: position = cycles since reset, cells as a plain array (-1 = never written)
  always @(posedge clk) begin
    int nn, hn, vn;
    if (rst) begin
      n = 0; m_busy = 0; m_fa = 0;
      exp_color = 0; exp_vb = 0; exp_fs = 0;
    end else begin
      nn = (n + 1) % (H_TOTAL * V_TOTAL);
      hn = nn % H_TOTAL;
      vn = nn / H_TOTAL;
      exp_color = (hn < H_VIS && vn < V_VIS) ? mem[(vn / 16) * COLS + hn / 16] : 0;
      exp_vb = vn >= V_VIS;
      exp_fs = nn == 0;
      if (bus.clr) begin
        m_busy = 1; m_fa = 0; m_fc = int'(bus.clr_color);
      end else if (m_busy != 0) begin
        mem[m_fa] = m_fc;
        if (m_fa == CELLS - 1) m_busy = 0; else m_fa++;
      end else if (bus.wr_en && bus.wr_x < COLS && bus.wr_y < ROWS)
        mem[int'(bus.wr_y) * COLS + int'(bus.wr_x)] = int'(bus.wr_color);
      n = nn;
    end
  end

  // every cycle: compare all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_color >= 0) chk("color", int'(bus.color), exp_color);
      chk("clr_busy", int'(bus.clr_busy), m_busy);
      chk("vblank", int'(bus.vblank), exp_vb);
      chk("frame_start", int'(bus.frame_start), exp_fs);
    end
  end

  task automatic wait_n(input int target);
    int k = 0;
    while (n != target && k < 450000) begin
      @(negedge clk);
      k++;
    end
    if (n != target) chk("wait_timeout", n, target);
  endtask

  task automatic busy_len(input string name, input int want);
    int cnt = 0;
    while (bus.clr_busy && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    chk(name, cnt, want);
  endtask

  task automatic pulse_clr(input int c);
    @(negedge clk);
    bus.clr = 1'b1;
    bus.clr_color = 3'(c);
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1200; i++) mem[i] = -1;
    bus.wr_en = 0; bus.wr_x = 0; bus.wr_y = 0; bus.wr_color = 0;
    bus.clr = 0; bus.clr_color = 0;
    wrs[0] = '{3, 2, RED};     wrs[1] = '{0, 0, BLUE};   wrs[2] = '{39, 0, CYAN};
    wrs[3] = '{40, 0, MAGENTA}; wrs[4] = '{0, 30, YELLOW}; wrs[5] = '{40, 1, BROWN};
    wrs[6] = '{39, 1, BLACK};  wrs[7] = '{10, 1, YELLOW};
    pix[0] = '{8, 8, 1};     pix[1] = '{24, 8, 7};    pix[2] = '{632, 8, 3};
    pix[3] = '{8, 16, 7};    pix[4] = '{168, 16, 6};  pix[5] = '{624, 31, 0};
    pix[6] = '{0, 32, 7};    pix[7] = '{47, 32, 7};   pix[8] = '{48, 32, 4};
    pix[9] = '{63, 40, 4};   pix[10] = '{48, 47, 4};  pix[11] = '{64, 47, 7};
    pix[12] = '{639, 47, 7}; pix[13] = '{640, 47, 0}; pix[14] = '{799, 47, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_color", int'(bus.color), 0);
    chk("rst_busy", int'(bus.clr_busy), 0);
    chk("rst_vblank", int'(bus.vblank), 0);
    chk("rst_fs", int'(bus.frame_start), 0);
    chk_en = 1;
    #5 rst = 1'b0;
    pulse_clr(WHITE);
    chk("clr_started", int'(bus.clr_busy), 1);
    busy_len("clr_len", 1200);
    foreach (wrs[i]) begin
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.wr_x = 6'(wrs[i].x);
      bus.wr_y = 5'(wrs[i].y);
      bus.wr_color = 3'(wrs[i].c);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    foreach (pix[i]) begin
      wait_n(pix[i].v * H_TOTAL + pix[i].h);
      chk($sformatf("pix_%0d_%0d", pix[i].h, pix[i].v), int'(bus.color), pix[i].e);
    end
    @(negedge clk);
    bus.clr = 1'b1; bus.clr_color = BLUE;
    bus.wr_en = 1'b1; bus.wr_x = 5; bus.wr_y = 0; bus.wr_color = RED;
    @(negedge clk);
    bus.clr = 1'b0;
    bus.wr_x = 6;
    for (int k = 0; k < 600; k++) begin
      bus.wr_en = k < 10;
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    chk("busy_mid_fill", int'(bus.clr_busy), 1);
    pulse_clr(CYAN);
    busy_len("restart_len", 1200);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      bus.wr_en = 1'($urandom);
      bus.wr_x = 6'($urandom_range(0, 41));
      bus.wr_y = 5'($urandom_range(0, 31));
      bus.wr_color = 3'($urandom);
      bus.clr = ($urandom % 600) == 0;
      bus.clr_color = 3'($urandom);
    end
    @(negedge clk);
    bus.wr_en = 1'b0; bus.clr = 1'b0;
    busy_len("random_drain", int'(bus.clr_busy) * m_busy * 0 + (bus.clr_busy ? 1200 - m_fa : 0));
    pulse_clr(YELLOW);
    repeat (500) @(negedge clk);
    wait_n((n / H_TOTAL + 1) * H_TOTAL + 300);
    #5 rst = 1'b1;
    #1;
    chk("arst_color", int'(bus.color), 0);
    chk("arst_busy", int'(bus.clr_busy), 0);
    chk("arst_vblank", int'(bus.vblank), 0);
    chk("arst_fs", int'(bus.frame_start), 0);
    repeat (3) @(negedge clk);
    #5 rst = 1'b0;
    repeat (13000) @(negedge clk);
    chk("post_rst_pos", n, 13000);
    chk("fill_aborted", int'(bus.clr_busy), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
